// File: rtl/axi_mm_pkg.sv
// Shared definitions for the HPS-facing register/pixel responder: register offsets,
// STATUS/CTRL bit positions, the default ID constant and the pixel FIFO entry layout.
package axi_mm_pkg;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4C50_4A01;

    localparam logic [2:0] REG_ID         = 3'd0;
    localparam logic [2:0] REG_CTRL       = 3'd1;
    localparam logic [2:0] REG_BGCOLOR    = 3'd2;
    localparam logic [2:0] REG_STATUS     = 3'd3;
    localparam logic [2:0] REG_FRAMECOUNT = 3'd4;
    localparam logic [2:0] REG_SCRATCH    = 3'd5;

    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_TESTPAT_BIT = 1;

    localparam int STATUS_HPD_BIT   = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_FULL_BIT  = 2;
    localparam int STATUS_LEVEL_LSB = 4;
    localparam int STATUS_LEVEL_W   = 7;

    typedef struct packed {
        logic [17:0] addr;
        logic [23:0] data;
    } fifo_entry_t;

    localparam int FIFO_ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pointers and level reset, storage does not.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 42,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/axi_mm_responder.sv
// HPS bridge responder: small register file plus a pixel window that queues
// framebuffer writes through a FIFO, stalling the initiator only when it is full.
module axi_mm_responder
    import axi_mm_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
    input  logic        FPGA_CLK1_50,
    input  logic        Reset,
    input  logic [18:0] AXI_Address,
    input  logic        AXI_Read,
    input  logic        AXI_Write,
    input  logic [31:0] AXI_WriteData,
    output logic [31:0] AXI_ReadData,
    output logic        AXI_ReadDataValid,
    output logic        AXI_WaitRequest,
    input  logic        ADV_HPD,
    input  logic        VSync_Pulse,
    output logic        Ctrl_Enable,
    output logic        Ctrl_TestPattern,
    output logic [23:0] Ctrl_BgColor,
    output logic [17:0] FB_WrAddr,
    output logic [23:0] FB_WrData,
    output logic        FB_WrValid,
    input  logic        FB_WrReady
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]  ctrl_q, ctrl_d;
    logic [23:0] bgcolor_q, bgcolor_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] framecount_q, framecount_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        hpd_meta_q, hpd_sync_q;

    logic        fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [STATUS_LEVEL_W-1:0] level_ext;
    fifo_entry_t push_entry, head_entry;
    logic        wr_acc, rd_acc, reg_wr, push;
    logic [31:0] status, rd_mux;

    assign AXI_WaitRequest = AXI_Write & AXI_Address[18] & fifo_full;
    assign wr_acc     = AXI_Write & ~AXI_WaitRequest;
    assign rd_acc     = AXI_Read & ~AXI_Write;
    assign reg_wr     = wr_acc & ~AXI_Address[18];
    assign push       = wr_acc & AXI_Address[18];
    assign push_entry = '{addr: AXI_Address[17:0], data: AXI_WriteData[23:0]};
    assign level_ext  = STATUS_LEVEL_W'(fifo_level);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_ENTRY_W)
    ) u_fifo (
        .clk_i   (FPGA_CLK1_50),
        .rst_i   (Reset),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (FB_WrReady),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        status = '0;
        status[STATUS_HPD_BIT]   = hpd_sync_q;
        status[STATUS_EMPTY_BIT] = fifo_empty;
        status[STATUS_FULL_BIT]  = fifo_full;
        status[STATUS_LEVEL_LSB +: STATUS_LEVEL_W] = level_ext;

        rd_mux = '0;
        if (!AXI_Address[18]) begin
            case (AXI_Address[2:0])
                REG_ID:         rd_mux = ID_VALUE;
                REG_CTRL:       rd_mux = {30'd0, ctrl_q};
                REG_BGCOLOR:    rd_mux = {8'd0, bgcolor_q};
                REG_STATUS:     rd_mux = status;
                REG_FRAMECOUNT: rd_mux = framecount_q;
                REG_SCRATCH:    rd_mux = scratch_q;
                default:        rd_mux = '0;
            endcase
        end
    end

    always_comb begin
        ctrl_d       = ctrl_q;
        bgcolor_d    = bgcolor_q;
        scratch_d    = scratch_q;
        framecount_d = framecount_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_acc;

        if (rd_acc) rd_data_d = rd_mux;
        if (VSync_Pulse) framecount_d = framecount_q + 32'd1;

        // The FRAMECOUNT clear is applied last so it overrides a coincident VSync.
        if (reg_wr) begin
            case (AXI_Address[2:0])
                REG_CTRL:       ctrl_d       = AXI_WriteData[1:0];
                REG_BGCOLOR:    bgcolor_d    = AXI_WriteData[23:0];
                REG_FRAMECOUNT: framecount_d = '0;
                REG_SCRATCH:    scratch_d    = AXI_WriteData;
                default:        ;
            endcase
        end
    end

    always_ff @(posedge FPGA_CLK1_50 or posedge Reset) begin
        if (Reset) begin
            ctrl_q       <= '0;
            bgcolor_q    <= '0;
            scratch_q    <= '0;
            framecount_q <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            hpd_meta_q   <= 1'b0;
            hpd_sync_q   <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            bgcolor_q    <= bgcolor_d;
            scratch_q    <= scratch_d;
            framecount_q <= framecount_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            hpd_meta_q   <= ADV_HPD;
            hpd_sync_q   <= hpd_meta_q;
        end
    end

    assign AXI_ReadData      = rd_data_q;
    assign AXI_ReadDataValid = rd_valid_q;
    assign Ctrl_Enable       = ctrl_q[CTRL_ENABLE_BIT];
    assign Ctrl_TestPattern  = ctrl_q[CTRL_TESTPAT_BIT];
    assign Ctrl_BgColor      = bgcolor_q;
    assign FB_WrValid        = ~fifo_empty;
    assign FB_WrAddr         = head_entry.addr;
    assign FB_WrData         = head_entry.data;

endmodule

// File: tb/tb_axi_mm_responder.sv
// Randomised self-checking bench for axi_mm_responder against a queue-based
// transaction model of the register map and pixel FIFO.
module tb_axi_mm_responder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] addr;
    logic        rd, wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid, waitreq;
    logic        hpd, vsync;
    logic        c_en, c_tp;
    logic [23:0] c_bg;
    logic [17:0] fb_addr;
    logic [23:0] fb_data;
    logic        fb_valid, fb_ready;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic [1:0]  m_ctrl;
    logic [23:0] m_bg;
    logic [31:0] m_scratch;
    logic [31:0] m_fc;
    logic [41:0] m_fifo[$];
    logic        m_hpd1, m_hpd2;
    logic        hpd_in;

    always #10 clk = ~clk;

    axi_mm_responder #(.FIFO_DEPTH(DEPTH)) dut (
        .FPGA_CLK1_50      (clk),
        .Reset             (rst),
        .AXI_Address       (addr),
        .AXI_Read          (rd),
        .AXI_Write         (wr),
        .AXI_WriteData     (wdata),
        .AXI_ReadData      (rdata),
        .AXI_ReadDataValid (rvalid),
        .AXI_WaitRequest   (waitreq),
        .ADV_HPD           (hpd),
        .VSync_Pulse       (vsync),
        .Ctrl_Enable       (c_en),
        .Ctrl_TestPattern  (c_tp),
        .Ctrl_BgColor      (c_bg),
        .FB_WrAddr         (fb_addr),
        .FB_WrData         (fb_data),
        .FB_WrValid        (fb_valid),
        .FB_WrReady        (fb_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [18:0] a);
        logic [31:0] lvl;
        if (a[18]) return 32'd0;
        lvl = m_fifo.size();
        case (a[2:0])
            3'd0: return 32'h4C50_4A01;
            3'd1: return {30'd0, m_ctrl};
            3'd2: return {8'd0, m_bg};
            3'd3: return (lvl << 4) | ((lvl == DEPTH) ? 32'd4 : 32'd0)
                         | ((lvl == 0) ? 32'd2 : 32'd0) | {31'd0, m_hpd2};
            3'd4: return m_fc;
            3'd5: return m_scratch;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_bg = '0; m_scratch = '0; m_fc = '0;
        m_fifo.delete();
        m_hpd1 = 1'b0; m_hpd2 = 1'b0;
    endtask

    // One bus cycle: drive at negedge, check pre-edge outputs, advance model at posedge.
    task automatic step(input logic r, input logic w, input logic [18:0] a,
                        input logic [31:0] d, input logic vs, input logic rdy,
                        output logic stalled);
        logic        exp_wait, racc;
        logic [31:0] exp_rd;
        logic [41:0] head;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d; vsync = vs; fb_ready = rdy; hpd = hpd_in;
        #1;
        exp_wait = w && a[18] && (m_fifo.size() == DEPTH);
        chk("waitreq", waitreq, exp_wait);
        chk("fb_valid", fb_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            head = m_fifo[0];
            chk("fb_addr", fb_addr, head[41:24]);
            chk("fb_data", fb_data, head[23:0]);
        end
        racc   = r && !w;
        exp_rd = model_read(a);
        @(posedge clk);
        if (m_fifo.size() != 0 && rdy) void'(m_fifo.pop_front());
        if (w && !exp_wait) begin
            if (a[18]) m_fifo.push_back({a[17:0], d[23:0]});
        end
        if (vs) m_fc = m_fc + 32'd1;
        if (w && !a[18]) begin
            case (a[2:0])
                3'd1: m_ctrl = d[1:0];
                3'd2: m_bg = d[23:0];
                3'd4: m_fc = 32'd0;
                3'd5: m_scratch = d;
                default: ;
            endcase
        end
        m_hpd2 = m_hpd1;
        m_hpd1 = hpd_in;
        #1;
        chk("rvalid", rvalid, racc);
        if (racc) chk("rdata", rdata, exp_rd);
        chk("ctrl", {c_tp, c_en}, m_ctrl);
        chk("bgcolor", c_bg, m_bg);
        stalled = exp_wait;
    endtask

    task automatic idle(input logic rdy);
        logic s;
        step(1'b0, 1'b0, 19'd0, 32'd0, 1'b0, rdy, s);
    endtask

    task automatic rreg(input logic [2:0] r);
        logic s;
        step(1'b1, 1'b0, {16'd0, r}, 32'd0, 1'b0, 1'b0, s);
    endtask

    initial begin
        logic        s, r, w, vs, rdy;
        logic [18:0] a;
        logic [31:0] d;
        int          guard;

        rst = 1'b1; rd = 0; wr = 0; addr = '0; wdata = '0; vsync = 0;
        fb_ready = 0; hpd = 0; hpd_in = 0;
        model_reset();
        #5;
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_fbvalid", fb_valid, 1'b0);
        chk("rst_bg", c_bg, 24'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;

        // ID read, BGCOLOR read-after-write, back-to-back reads
        rreg(3'd0);
        step(1'b0, 1'b1, 19'd2, 32'h00AB_CDEF, 1'b0, 1'b0, s);
        rreg(3'd2);
        step(1'b0, 1'b1, 19'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, s);
        rreg(3'd1); rreg(3'd0); rreg(3'd3);
        step(1'b1, 1'b0, 19'h4_0005, 32'd0, 1'b0, 1'b0, s);

        // fill FIFO, stall on the 17th, then drain in order
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, {1'b1, 18'(i * 37 + 5)}, 32'hAA00_0000 | 32'(i), 1'b0, 1'b0, s);
        step(1'b0, 1'b1, {1'b1, 18'h3_FFFF}, 32'h0012_3456, 1'b0, 1'b0, s);
        chk("stall17", s, 1'b1);
        rreg(3'd3);
        guard = 0;
        do begin
            step(1'b0, 1'b1, {1'b1, 18'h3_FFFF}, 32'h0012_3456, 1'b0, 1'b1, s);
            guard++;
        end while (s && guard < 50);
        chk("stall_release", s, 1'b0);
        repeat (DEPTH + 2) idle(1'b1);
        rreg(3'd3);

        // FRAMECOUNT wrap and clear-wins
        @(negedge clk);
        force dut.framecount_q = 32'hFFFF_FFFF;
        m_fc = 32'hFFFF_FFFF;
        idle(1'b0);
        release dut.framecount_q;
        rreg(3'd4);
        step(1'b0, 1'b0, 19'd0, 32'd0, 1'b1, 1'b0, s);
        rreg(3'd4);
        step(1'b0, 1'b0, 19'd0, 32'd0, 1'b1, 1'b0, s);
        step(1'b0, 1'b0, 19'd0, 32'd0, 1'b1, 1'b0, s);
        rreg(3'd4);
        step(1'b0, 1'b1, 19'd4, 32'h5555_5555, 1'b1, 1'b0, s);
        rreg(3'd4);

        // read+write together to SCRATCH
        step(1'b1, 1'b1, 19'd5, 32'h1234_5678, 1'b0, 1'b0, s);
        idle(1'b0);
        rreg(3'd5);

        // HPD synchroniser
        hpd_in = 1'b1;
        rreg(3'd3); rreg(3'd3); rreg(3'd3);

        // randomised traffic
        s = 1'b0; r = 0; w = 0; a = '0; d = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!s) begin
                int sel = $urandom_range(0, 99);
                r = (sel < 45) || (sel >= 95);
                w = (sel >= 45);
                a = 19'($urandom);
                if ($urandom_range(0, 1) == 1) a[18] = 1'b1;
                if (!a[18] && w && a[2:0] == 3'd4 && $urandom_range(0, 3) != 0) a[2:0] = 3'd5;
                d = $urandom;
            end
            vs  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 63) == 0) hpd_in = ~hpd_in;
            step(r, w, a, d, vs, rdy, s);
        end
        guard = 0;
        while (s && guard < 50) begin
            step(r, w, a, d, 1'b0, 1'b1, s);
            guard++;
        end
        chk("rand_drain", s, 1'b0);

        // reset with pending FIFO entries and a read in flight
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, {1'b1, 18'(i + 100)}, 32'(i), 1'b0, 1'b0, s);
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = 19'd0; fb_ready = 1'b0; vsync = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_rvalid", rvalid, 1'b1);
        chk("pre_rst_fbvalid", fb_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_fbvalid", fb_valid, 1'b0);
        chk("mid_rst_ctrl", {c_tp, c_en}, 2'b00);
        model_reset();
        rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rreg(3'd3);
        rreg(3'd5);
        rreg(3'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
